// File: rtl/rns_fwd_conv_arbiter_pkg.sv
// Shared definitions for the RNS forward-converter arbiter: moduli set (32,31,21,5),
// residue bundle and controller state encoding.
package rns_pkg;

    localparam int MOD_1      = 32;
    localparam int MOD_2      = 31;
    localparam int MOD_3      = 21;
    localparam int MOD_4      = 5;
    localparam int MOD_SIZE_1 = 5;
    localparam int MOD_SIZE_2 = 5;
    localparam int MOD_SIZE_3 = 5;
    localparam int MOD_SIZE_4 = 3;
    localparam int DYN_SIZE   = 16;

    typedef struct packed {
        logic [MOD_SIZE_1-1:0] m32;
        logic [MOD_SIZE_2-1:0] m31;
        logic [MOD_SIZE_3-1:0] m21;
        logic [MOD_SIZE_4-1:0] m5;
    } rns_res_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rns_fwd_conv_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr,
// searching modulo NUM_REQ, and reports the one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);
    import rns_pkg::*;

    always_comb begin : search
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req[ID_W'(idx)]) begin
                grant[ID_W'(idx)] = 1'b1;
                grant_idx         = ID_W'(idx);
                grant_any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rns_fwd_conv_arbiter.sv
// Shares one binary-to-RNS forward converter between NUM_REQ requesters with round-robin
// arbitration. Define RNS_ARB_SELFCHECK_EN to add the chk_err/chk_id converter self-check.
module rns_fwd_conv_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DYN_SIZE = 16,
    parameter int CONV_LAT = 1,
    parameter int ID_W     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DYN_SIZE-1:0] req_data,
    output logic [DYN_SIZE-1:0]         conv_n,
    input  logic [4:0]                  conv_res_m32,
    input  logic [4:0]                  conv_res_m31,
    input  logic [4:0]                  conv_res_m21,
    input  logic [2:0]                  conv_res_m5,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [4:0]                  rsp_m32,
    output logic [4:0]                  rsp_m31,
    output logic [4:0]                  rsp_m21,
    output logic [2:0]                  rsp_m5,
    output logic                        busy
`ifdef RNS_ARB_SELFCHECK_EN
    ,
    output logic                        chk_err,
    output logic [ID_W-1:0]             chk_id
`endif
);
    import rns_pkg::*;

    localparam int CNT_W = 3;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DYN_SIZE-1:0] conv_n_q, conv_n_d;
    rns_res_t            rsp_res_q, rsp_res_d;
    logic                rsp_valid_q, rsp_valid_d;
    rns_res_t            conv_res;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic                capture;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign conv_res = {conv_res_m32, conv_res_m31, conv_res_m21, conv_res_m5};
    assign capture  = (state_q == ST_WAIT) && (cnt_q <= CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            rsp_id_q    <= '0;
            conv_n_q    <= '0;
            rsp_res_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_id_q    <= rsp_id_d;
            conv_n_q    <= conv_n_d;
            rsp_res_q   <= rsp_res_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_any) state_d = ST_WAIT;
            ST_WAIT: if (capture)   state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The operand register doubles as conv_n, so it only moves on an accept.
    always_comb begin
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_id_d    = rsp_id_q;
        conv_n_d    = conv_n_q;
        rsp_res_d   = rsp_res_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    conv_n_d = req_data[int'(grant_idx)*DYN_SIZE +: DYN_SIZE];
                    rsp_id_d = grant_idx;
                    cnt_d    = CNT_W'(CONV_LAT);
                    rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (capture) begin
                    rsp_res_d   = conv_res;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE && !reset) ? grant : '0;
        busy      = (state_q != ST_IDLE);
        conv_n    = conv_n_q;
        rsp_valid = rsp_valid_q;
        rsp_id    = rsp_id_q;
        rsp_m32   = rsp_res_q.m32;
        rsp_m31   = rsp_res_q.m31;
        rsp_m21   = rsp_res_q.m21;
        rsp_m5    = rsp_res_q.m5;
    end

`ifdef RNS_ARB_SELFCHECK_EN
    logic            chk_err_q, chk_err_d;
    logic [ID_W-1:0] chk_id_q, chk_id_d;
    logic            mismatch;

    // Only the first failing requester is remembered; the error flag is sticky until reset.
    always_comb begin
        mismatch = (DYN_SIZE'(conv_res.m32) != conv_n_q % DYN_SIZE'(MOD_1)) ||
                   (DYN_SIZE'(conv_res.m31) != conv_n_q % DYN_SIZE'(MOD_2)) ||
                   (DYN_SIZE'(conv_res.m21) != conv_n_q % DYN_SIZE'(MOD_3)) ||
                   (DYN_SIZE'(conv_res.m5)  != conv_n_q % DYN_SIZE'(MOD_4));
        chk_err_d = chk_err_q;
        chk_id_d  = chk_id_q;
        if (capture && mismatch) begin
            chk_err_d = 1'b1;
            if (!chk_err_q) chk_id_d = rsp_id_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_err_q <= 1'b0;
            chk_id_q  <= '0;
        end else begin
            chk_err_q <= chk_err_d;
            chk_id_q  <= chk_id_d;
        end
    end

    assign chk_err = chk_err_q;
    assign chk_id  = chk_id_q;
`endif

endmodule

// File: tb/tb_rns_fwd_conv_arbiter.sv
// Self-checking bench for rns_fwd_conv_arbiter: transaction-level reference model,
// latency-accurate converter model, directed scenarios followed by randomized traffic.
module tb_rns_fwd_conv_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DYN_SIZE = 16;
    localparam int CONV_LAT = 3;
    localparam int ID_W     = 2;

    localparam int P_IDLE = 0;
    localparam int P_CONV = 1;
    localparam int P_RESP = 2;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*DYN_SIZE-1:0] req_data;
    logic [DYN_SIZE-1:0]         conv_n;
    logic [DYN_SIZE-1:0]         conv_src;
    logic [4:0]                  conv_res_m32, conv_res_m31, conv_res_m21;
    logic [2:0]                  conv_res_m5;
    logic                        rsp_valid, rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [4:0]                  rsp_m32, rsp_m31, rsp_m21;
    logic [2:0]                  rsp_m5;
    logic                        busy;
    logic                        corrupt_m21;
    bit                          cmp_en = 1'b0;
`ifdef RNS_ARB_SELFCHECK_EN
    logic                        chk_err;
    logic [ID_W-1:0]             chk_id;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rns_fwd_conv_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DYN_SIZE (DYN_SIZE),
        .CONV_LAT (CONV_LAT),
        .ID_W     (ID_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .conv_n       (conv_n),
        .conv_res_m32 (conv_res_m32),
        .conv_res_m31 (conv_res_m31),
        .conv_res_m21 (conv_res_m21),
        .conv_res_m5  (conv_res_m5),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_m32      (rsp_m32),
        .rsp_m31      (rsp_m31),
        .rsp_m21      (rsp_m21),
        .rsp_m5       (rsp_m5),
        .busy         (busy)
`ifdef RNS_ARB_SELFCHECK_EN
        ,
        .chk_err      (chk_err),
        .chk_id       (chk_id)
`endif
    );

    always #5 clk = ~clk;

    // Converter model: residues only reflect a new conv_n once it has been stable CONV_LAT cycles.
    logic [DYN_SIZE-1:0] hist [0:7];
    initial for (int k = 0; k < 8; k++) hist[k] = '0;
    always @(negedge clk) begin
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = conv_n;
    end
    assign conv_src     = hist[CONV_LAT-1];
    assign conv_res_m32 = 5'(conv_src % 16'd32);
    assign conv_res_m31 = 5'(conv_src % 16'd31);
    assign conv_res_m21 = 5'(conv_src % 16'd21) ^ {4'b0, corrupt_m21};
    assign conv_res_m5  = 3'(conv_src % 16'd5);

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        int idx;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ptr + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference model: one transaction at a time, results due CONV_LAT cycles after accept.
    int              m_phase, m_ptr, m_id, m_cyc, m_due;
    logic [15:0]     m_op;
    bit              m_rsp_valid;
    int              m_r32, m_r31, m_r21, m_r5;
    bit              m_chk_err;
    int              m_chk_id;

    always @(posedge clk or posedge reset) begin
        int g;
        if (reset) begin
            m_phase = P_IDLE; m_ptr = 0; m_id = 0; m_cyc = 0; m_due = 0; m_op = '0;
            m_rsp_valid = 1'b0; m_r32 = 0; m_r31 = 0; m_r21 = 0; m_r5 = 0;
            m_chk_err = 1'b0; m_chk_id = 0;
        end else begin
            m_cyc++;
            case (m_phase)
                P_IDLE: begin
                    g = pick(req_valid, m_ptr);
                    if (g >= 0) begin
                        m_op    = req_data[g*DYN_SIZE +: DYN_SIZE];
                        m_id    = g;
                        m_ptr   = (g + 1) % NUM_REQ;
                        m_due   = m_cyc + CONV_LAT;
                        m_phase = P_CONV;
                    end
                end
                P_CONV: begin
                    if (m_cyc == m_due) begin
                        m_r32 = m_op % 32;
                        m_r31 = m_op % 31;
                        m_r21 = (m_op % 21) ^ int'(corrupt_m21);
                        m_r5  = m_op % 5;
                        m_rsp_valid = 1'b1;
                        m_phase     = P_RESP;
                        if (corrupt_m21 && !m_chk_err) begin
                            m_chk_err = 1'b1;
                            m_chk_id  = m_id;
                        end
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        m_rsp_valid = 1'b0;
                        m_phase     = P_IDLE;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison of the DUT against the reference model.
    always @(negedge clk) begin
        int g;
        logic [NUM_REQ-1:0] exp_ready;
        if (!reset && cmp_en) begin
            g = pick(req_valid, m_ptr);
            exp_ready = (m_phase == P_IDLE && g >= 0) ? (NUM_REQ'(1) << g) : '0;
            checkOutput("req_ready", int'(req_ready), int'(exp_ready));
            checkOutput("busy", int'(busy), int'(m_phase != P_IDLE));
            checkOutput("rsp_valid", int'(rsp_valid), int'(m_rsp_valid));
            checkOutput("conv_n", int'(conv_n), int'(m_op));
            checkOutput("rsp_id", int'(rsp_id), m_id);
            if (m_rsp_valid) begin
                checkOutput("rsp_m32", int'(rsp_m32), m_r32);
                checkOutput("rsp_m31", int'(rsp_m31), m_r31);
                checkOutput("rsp_m21", int'(rsp_m21), m_r21);
                checkOutput("rsp_m5", int'(rsp_m5), m_r5);
            end
`ifdef RNS_ARB_SELFCHECK_EN
            checkOutput("chk_err", int'(chk_err), int'(m_chk_err));
            if (m_chk_err) checkOutput("chk_id", int'(chk_id), m_chk_id);
`endif
        end
    end

    task automatic waitReady(input logic [NUM_REQ-1:0] mask, output int idx);
        idx = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ((req_ready & mask) != '0) begin
                for (int b = NUM_REQ - 1; b >= 0; b--) if (req_ready[b]) idx = b;
                break;
            end
        end
        if (idx < 0) reportTimeout("grant_wait");
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) reportTimeout("idle_wait");
    endtask

    // Presents one operand on one requester and returns the request-to-response cycle count.
    task automatic applyStimulus(input int idx, input logic [15:0] op, output int lat);
        int gi;
        @(posedge clk); #1;
        req_data[idx*DYN_SIZE +: DYN_SIZE] = op;
        req_valid = NUM_REQ'(1) << idx;
        waitReady(req_valid, gi);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            req_valid = '0;
            lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (!rsp_valid) reportTimeout("rsp_wait");
    endtask

    initial begin
        int lat, gi, seen, r;
        reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1; corrupt_m21 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_req_ready", int'(req_ready), 0);
        checkOutput("reset_conv_n", int'(conv_n), 0);
        checkOutput("reset_rsp_id", int'(rsp_id), 0);
        checkOutput("reset_rsp_m32", int'(rsp_m32), 0);
        reset = 1'b0;
        cmp_en = 1'b1;

        $display("[TB] T1 single request");
        applyStimulus(0, 16'd1000, lat);
        checkOutput("t1_latency", lat, CONV_LAT + 1);
        checkOutput("t1_rsp_id", int'(rsp_id), 0);
        checkOutput("t1_m32", int'(rsp_m32), 8);
        checkOutput("t1_m31", int'(rsp_m31), 8);
        checkOutput("t1_m21", int'(rsp_m21), 13);
        checkOutput("t1_m5", int'(rsp_m5), 0);

        $display("[TB] T2 boundary operands");
        applyStimulus(2, 16'hFFFF, lat);
        checkOutput("t2_rsp_id", int'(rsp_id), 2);
        checkOutput("t2_max_m32", int'(rsp_m32), 31);
        checkOutput("t2_max_m31", int'(rsp_m31), 1);
        checkOutput("t2_max_m21", int'(rsp_m21), 15);
        checkOutput("t2_max_m5", int'(rsp_m5), 0);
        applyStimulus(3, 16'd0, lat);
        checkOutput("t2_zero_res", int'({rsp_m32, rsp_m31, rsp_m21, rsp_m5}), 0);

        $display("[TB] T3 rotating priority");
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DYN_SIZE +: DYN_SIZE] = 16'($urandom);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            waitReady('1, gi);
            checkOutput("t3_onehot", $countones(req_ready), 1);
            checkOutput("t3_grant_order", gi, k % NUM_REQ);
            @(posedge clk); #1;
        end
        req_valid = '0;
        waitIdle();

        $display("[TB] T4 response back-pressure");
        rsp_ready = 1'b0;
        applyStimulus(1, 16'd4321, lat);
        checkOutput("t4_latency", lat, CONV_LAT + 1);
        @(posedge clk); #1;
        req_valid = '1;
        repeat (10) @(negedge clk);
        checkOutput("t4_rsp_valid_held", int'(rsp_valid), 1);
        checkOutput("t4_no_ready", int'(req_ready), 0);
        checkOutput("t4_rsp_id", int'(rsp_id), 1);
        checkOutput("t4_m32", int'(rsp_m32), 1);
        checkOutput("t4_m31", int'(rsp_m31), 12);
        checkOutput("t4_m21", int'(rsp_m21), 16);
        checkOutput("t4_m5", int'(rsp_m5), 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t4_released_valid", int'(rsp_valid), 0);
        checkOutput("t4_released_busy", int'(busy), 0);

        $display("[TB] T5 reset during conversion");
        @(posedge clk); #1;
        req_data[2*DYN_SIZE +: DYN_SIZE] = 16'd555;
        req_valid = 4'b0100;
        waitReady(4'b0100, gi);
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b1;
        #1;
        checkOutput("t5_reset_busy", int'(busy), 0);
        checkOutput("t5_reset_valid", int'(rsp_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (CONV_LAT + 4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checkOutput("t5_dropped_rsp", seen, 0);
        @(posedge clk); #1;
        req_valid = 4'b1010;
        waitReady('1, gi);
        checkOutput("t5_first_grant", gi, 1);
        @(posedge clk); #1;
        req_valid = '0;
        waitIdle();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            req_valid = NUM_REQ'($urandom_range(0, 15));
            for (int i = 0; i < NUM_REQ; i++) begin
                r = $urandom_range(0, 9);
                req_data[i*DYN_SIZE +: DYN_SIZE] = (r == 0) ? 16'h0000 :
                                                   (r == 1) ? 16'hFFFF : 16'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        waitIdle();

`ifdef RNS_ARB_SELFCHECK_EN
        $display("[TB] T6 converter self-check");
        corrupt_m21 = 1'b1;
        applyStimulus(1, 16'd1234, lat);
        checkOutput("t6_chk_err", int'(chk_err), 1);
        checkOutput("t6_chk_id", int'(chk_id), 1);
        @(posedge clk); #1;
        corrupt_m21 = 1'b0;
        applyStimulus(0, 16'd77, lat);
        checkOutput("t6_chk_err_sticky", int'(chk_err), 1);
        checkOutput("t6_chk_id_sticky", int'(chk_id), 1);
        waitIdle();
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("t6_chk_err_cleared", int'(chk_err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
